// File: rtl/bsg_test_master_pkg.sv
// Shared types and helpers for the DRAM bandwidth test master.
// Imported by the credit counter and the top-level statistics block.
package bsg_test_master_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    // Per-cycle events that drive the statistics counters
    typedef struct packed {
        logic busy;
        logic issue_read;
        logic issue_write;
    } stat_evt_s;

    // Bits needed to hold the values 0..max_outstanding inclusive
    function automatic int unsigned credit_width(input int unsigned max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/bsg_test_master_credit.sv
// Credit pool: down by 0..1 per issue, up by 0..2 per response, clamped at the pool size.
// Responses that would overfill the pool are dropped and flagged.
module bsg_test_master_credit
    import bsg_test_master_pkg::*;
#(
    parameter int unsigned max_outstanding_p = 4,
    parameter int unsigned width_p           = credit_width(max_outstanding_p)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               take_i,
    input  logic               data_ret_i,
    input  logic               write_ret_i,
    output logic [width_p-1:0] credits_o,
    output logic [width_p-1:0] in_flight_o,
    output logic [width_p-1:0] in_flight_next_o,
    output logic               overflow_o
);

    localparam logic [width_p-1:0] max_lp     = width_p'(max_outstanding_p);
    localparam logic [width_p+1:0] max_ext_lp = (width_p + 2)'(max_outstanding_p);

    logic [width_p-1:0] credits_q, credits_d;
    logic [width_p+1:0] sum;
    logic               take_eff;

    // The issue rule never takes from an empty pool; the guard keeps the counter safe anyway
    assign take_eff = take_i & (credits_q != '0);

    always_comb begin
        sum = {2'b00, credits_q}
            - {{(width_p + 1){1'b0}}, take_eff}
            + {{(width_p + 1){1'b0}}, data_ret_i}
            + {{(width_p + 1){1'b0}}, write_ret_i};
        overflow_o = (sum > max_ext_lp);
        credits_d  = overflow_o ? max_lp : sum[width_p-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            credits_q <= max_lp;
        end else begin
            credits_q <= credits_d;
        end
    end

    assign credits_o        = credits_q;
    assign in_flight_o      = max_lp - credits_q;
    assign in_flight_next_o = max_lp - credits_d;

endmodule

// File: rtl/bsg_test_master_stats.sv
// DRAM bandwidth test master: issues a programmed number of requests under a credit cap
// and accumulates cycle, request, occupancy and peak-occupancy statistics.
module bsg_test_master_stats
    import bsg_test_master_pkg::*;
#(
    parameter int unsigned channel_addr_width_p = 16,
    parameter int unsigned max_outstanding_p    = 4,
    parameter int unsigned count_width_p        = 32,
    localparam int unsigned cred_width_lp       = credit_width(max_outstanding_p)
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            start_i,
    input  logic [count_width_p-1:0]        num_req_i,
    input  logic                            v_i,
    input  logic [channel_addr_width_p-1:0] ch_addr_i,
    input  logic                            write_not_read_i,
    output logic                            yumi_o,
    output logic                            dram_v_o,
    output logic [channel_addr_width_p-1:0] dram_ch_addr_o,
    output logic                            dram_write_not_read_o,
    input  logic                            dram_yumi_i,
    input  logic                            dram_data_v_i,
    input  logic                            dram_write_done_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            err_o,
    output logic [count_width_p-1:0]        cycles_o,
    output logic [count_width_p-1:0]        reads_o,
    output logic [count_width_p-1:0]        writes_o,
    output logic [count_width_p-1:0]        outstanding_sum_o,
    output logic [cred_width_lp-1:0]        max_outstanding_o
);

    localparam logic [cred_width_lp-1:0] max_cred_lp = cred_width_lp'(max_outstanding_p);

    state_e                   state_q, state_d;
    logic [count_width_p-1:0] target_q, target_d;
    logic [count_width_p-1:0] issued_q, issued_d;
    logic [count_width_p-1:0] cycles_q, cycles_d;
    logic [count_width_p-1:0] reads_q, reads_d;
    logic [count_width_p-1:0] writes_q, writes_d;
    logic [count_width_p-1:0] sum_q, sum_d;
    logic [cred_width_lp-1:0] max_q, max_d;
    logic                     err_q, err_d;

    logic [cred_width_lp-1:0] credits;
    logic [cred_width_lp-1:0] in_flight;
    logic [cred_width_lp-1:0] in_flight_next;
    logic                     overflow;
    logic                     issue;
    logic                     clear;
    stat_evt_s                evt;

    function automatic logic [count_width_p-1:0] sat_add(
        input logic [count_width_p-1:0] a,
        input logic [count_width_p-1:0] b
    );
        logic [count_width_p:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[count_width_p] ? '1 : s[count_width_p-1:0];
    endfunction

    // Zero-cycle request path: valid never depends on the DRAM accept
    assign dram_v_o              = (state_q == StRun) & v_i & (credits != '0);
    assign yumi_o                = dram_v_o & dram_yumi_i;
    assign issue                 = yumi_o;
    assign dram_ch_addr_o        = ch_addr_i;
    assign dram_write_not_read_o = write_not_read_i;

    bsg_test_master_credit #(
        .max_outstanding_p(max_outstanding_p),
        .width_p          (cred_width_lp)
    ) u_credit (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .take_i          (issue),
        .data_ret_i      (dram_data_v_i),
        .write_ret_i     (dram_write_done_i),
        .credits_o       (credits),
        .in_flight_o     (in_flight),
        .in_flight_next_o(in_flight_next),
        .overflow_o      (overflow)
    );

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        issued_d = issued_q;
        clear    = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    clear    = 1'b1;
                    target_d = num_req_i;
                    issued_d = '0;
                    state_d  = (num_req_i == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (issue) begin
                    issued_d = issued_q + count_width_p'(1);
                    if (issued_d == target_q) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (credits == max_cred_lp) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        evt.busy        = (state_q == StRun) | (state_q == StDrain);
        evt.issue_read  = issue & ~write_not_read_i;
        evt.issue_write = issue & write_not_read_i;

        cycles_d = cycles_q;
        reads_d  = reads_q;
        writes_d = writes_q;
        sum_d    = sum_q;
        max_d    = max_q;
        if (clear) begin
            cycles_d = '0;
            reads_d  = '0;
            writes_d = '0;
            sum_d    = '0;
            max_d    = '0;
        end else if (evt.busy) begin
            cycles_d = sat_add(cycles_q, count_width_p'(1));
            sum_d    = sat_add(sum_q, count_width_p'(in_flight));
            if (evt.issue_read) begin
                reads_d = sat_add(reads_q, count_width_p'(1));
            end
            if (evt.issue_write) begin
                writes_d = sat_add(writes_q, count_width_p'(1));
            end
            if (in_flight_next > max_q) begin
                max_d = in_flight_next;
            end
        end

        // A spurious response in the start cycle still counts as an error
        err_d = overflow | (err_q & ~clear);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            target_q <= '0;
            issued_q <= '0;
            cycles_q <= '0;
            reads_q  <= '0;
            writes_q <= '0;
            sum_q    <= '0;
            max_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            issued_q <= issued_d;
            cycles_q <= cycles_d;
            reads_q  <= reads_d;
            writes_q <= writes_d;
            sum_q    <= sum_d;
            max_q    <= max_d;
            err_q    <= err_d;
        end
    end

    assign busy_o            = (state_q == StRun) | (state_q == StDrain);
    assign done_o            = (state_q == StDone);
    assign err_o             = err_q;
    assign cycles_o          = cycles_q;
    assign reads_o           = reads_q;
    assign writes_o          = writes_q;
    assign outstanding_sum_o = sum_q;
    assign max_outstanding_o = max_q;

endmodule

// File: tb/tb_bsg_test_master_stats.sv
// Self-checking bench for bsg_test_master_stats: directed scenarios plus randomized runs,
// every cycle compared against a behavioural model of the credit/statistics rules.
module tb_bsg_test_master_stats;

    localparam int AW  = 8;
    localparam int MAX = 4;
    localparam int CW  = 32;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_DONE  = 3;

    logic          clk = 1'b0;
    logic          reset_i, start_i, v_i, write_not_read_i;
    logic [CW-1:0] num_req_i;
    logic [AW-1:0] ch_addr_i;
    logic          yumi_o, dram_v_o, dram_write_not_read_o;
    logic [AW-1:0] dram_ch_addr_o;
    logic          dram_yumi_i, dram_data_v_i, dram_write_done_i;
    logic          busy_o, done_o, err_o;
    logic [CW-1:0] cycles_o, reads_o, writes_o, outstanding_sum_o;
    logic [2:0]    max_outstanding_o;

    always #5 clk = ~clk;

    bsg_test_master_stats #(
        .channel_addr_width_p(AW),
        .max_outstanding_p   (MAX),
        .count_width_p       (CW)
    ) dut (
        .clk_i                (clk),
        .reset_i              (reset_i),
        .start_i              (start_i),
        .num_req_i            (num_req_i),
        .v_i                  (v_i),
        .ch_addr_i            (ch_addr_i),
        .write_not_read_i     (write_not_read_i),
        .yumi_o               (yumi_o),
        .dram_v_o             (dram_v_o),
        .dram_ch_addr_o       (dram_ch_addr_o),
        .dram_write_not_read_o(dram_write_not_read_o),
        .dram_yumi_i          (dram_yumi_i),
        .dram_data_v_i        (dram_data_v_i),
        .dram_write_done_i    (dram_write_done_i),
        .busy_o               (busy_o),
        .done_o               (done_o),
        .err_o                (err_o),
        .cycles_o             (cycles_o),
        .reads_o              (reads_o),
        .writes_o             (writes_o),
        .outstanding_sum_o    (outstanding_sum_o),
        .max_outstanding_o    (max_outstanding_o)
    );

    int tests = 0;
    int fails = 0;

    // Reference model
    int     m_state, m_credits, m_max;
    longint m_target, m_issued, m_cycles, m_reads, m_writes, m_sum;
    bit     m_err, m_valid;

    // Stimulus controls
    bit g_v, g_yumi, g_wnr, g_alt, g_rand, alt_bit;
    int g_lat;
    bit p_start, p_reset, p_dv, p_wd;
    int p_num;
    int cyc, n_issue;

    typedef struct {
        int due;
        bit w;
    } resp_t;
    resp_t rq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sat(input longint x);
        return (x > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : x;
    endfunction

    task automatic model_reset();
        m_state   = M_IDLE;
        m_credits = MAX;
        m_max     = 0;
        m_target  = 0;
        m_issued  = 0;
        m_cycles  = 0;
        m_reads   = 0;
        m_writes  = 0;
        m_sum     = 0;
        m_err     = 0;
    endtask

    task automatic step();
        bit exp_v, exp_yumi, busy, ovf, dv, wd;
        int nc, infl, ri, wi;
        if (g_rand) begin
            v_i              = ($urandom_range(0, 3) != 0);
            dram_yumi_i      = ($urandom_range(0, 3) != 0);
            write_not_read_i = $urandom_range(0, 1);
        end else begin
            v_i              = g_v;
            dram_yumi_i      = g_yumi;
            write_not_read_i = g_alt ? alt_bit : g_wnr;
        end
        ch_addr_i = AW'($urandom);
        start_i   = p_start;
        num_req_i = CW'(p_num);
        reset_i   = p_reset;
        dv        = p_dv;
        wd        = p_wd;
        p_start   = 0;
        p_reset   = 0;
        p_dv      = 0;
        p_wd      = 0;
        ri        = -1;
        wi        = -1;
        foreach (rq[i]) begin
            if (rq[i].due >= 0 && rq[i].due <= cyc) begin
                if (!rq[i].w && ri < 0 && !dv) ri = i;
                if (rq[i].w && wi < 0 && !wd) wi = i;
            end
        end
        if (ri >= 0) dv = 1;
        if (wi >= 0) wd = 1;
        if (ri > wi) begin
            rq.delete(ri);
            if (wi >= 0) rq.delete(wi);
        end else begin
            if (wi >= 0) rq.delete(wi);
            if (ri >= 0) rq.delete(ri);
        end
        dram_data_v_i     = dv;
        dram_write_done_i = wd;
        #1;

        busy     = (m_state == M_RUN) || (m_state == M_DRAIN);
        exp_v    = (m_state == M_RUN) && v_i && (m_credits != 0);
        exp_yumi = exp_v && dram_yumi_i;
        if (m_valid) begin
            chk("dram_v", dram_v_o, exp_v);
            chk("yumi", yumi_o, exp_yumi);
            chk("busy", busy_o, busy);
            chk("done", done_o, m_state == M_DONE);
            chk("err", err_o, m_err);
            chk("cycles", cycles_o, m_cycles);
            chk("reads", reads_o, m_reads);
            chk("writes", writes_o, m_writes);
            chk("osum", outstanding_sum_o, m_sum);
            chk("max_out", max_outstanding_o, m_max);
            if (exp_v) begin
                chk("addr_pass", dram_ch_addr_o, ch_addr_i);
                chk("wnr_pass", dram_write_not_read_o, write_not_read_i);
            end
        end
        if (yumi_o === 1'b1) n_issue++;

        if (reset_i) begin
            model_reset();
            m_valid = 1;
        end else begin
            infl = MAX - m_credits;
            nc   = m_credits - int'(exp_yumi) + int'(dv) + int'(wd);
            ovf  = (nc > MAX);
            if (ovf) nc = MAX;
            if (busy) begin
                m_cycles = sat(m_cycles + 1);
                m_sum    = sat(m_sum + infl);
                if (exp_yumi && write_not_read_i) m_writes = sat(m_writes + 1);
                if (exp_yumi && !write_not_read_i) m_reads = sat(m_reads + 1);
                if (MAX - nc > m_max) m_max = MAX - nc;
            end
            case (m_state)
                M_IDLE, M_DONE: if (start_i) begin
                    m_cycles = 0; m_reads = 0; m_writes = 0; m_sum = 0; m_max = 0;
                    m_err    = 0;
                    m_target = p_num;
                    m_issued = 0;
                    m_state  = (num_req_i == 0) ? M_DONE : M_RUN;
                end
                M_RUN: if (exp_yumi) begin
                    m_issued++;
                    if (m_issued == m_target) m_state = M_DRAIN;
                end
                M_DRAIN: if (m_credits == MAX) m_state = M_DONE;
                default: ;
            endcase
            if (ovf) m_err = 1;
            m_credits = nc;
            if (exp_yumi) begin
                resp_t r;
                r.w   = write_not_read_i;
                r.due = g_rand ? cyc + int'($urandom_range(1, 6)) : (g_lat == 0 ? -1 : cyc + g_lat);
                rq.push_back(r);
                alt_bit = ~alt_bit;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic release_held();
        int k = 1;
        foreach (rq[i]) begin
            if (rq[i].due < 0) begin
                rq[i].due = cyc + k;
                k++;
            end
        end
    endtask

    task automatic run_until_done(input int num, input int budget);
        int n = 0;
        p_start = 1;
        p_num   = num;
        do begin
            step();
            n++;
        end while (m_state != M_DONE && n < budget);
        chk("run_in_budget", n < budget, 1'b1);
        chk("run_done", done_o, 1'b1);
    endtask

    initial begin
        m_valid = 0;
        model_reset();
        {g_v, g_yumi, g_wnr, g_alt, g_rand, alt_bit} = '0;
        g_lat = 0;
        {p_start, p_dv, p_wd} = '0;
        p_num   = 0;
        cyc     = 0;
        n_issue = 0;
        p_reset = 1;
        @(posedge clk);
        #1;
        step();
        steps(2);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_max", max_outstanding_o, 3'd0);

        // Credit cap: 4 issues then stall; one returned read allows exactly one more
        g_v = 1; g_yumi = 1; g_lat = 0;
        p_start = 1; p_num = 10;
        n_issue = 0;
        steps(8);
        chk("cap_four_issues", n_issue, 4);
        chk("cap_stalled", dram_v_o, 1'b0);
        p_dv = 1;
        n_issue = 0;
        steps(3);
        chk("one_credit_one_issue", n_issue, 1);
        chk("cap_peak", max_outstanding_o, 3'd4);
        g_lat = 2;
        release_held();
        begin
            int n = 0;
            while (m_state != M_DONE && n < 80) begin
                step();
                n++;
            end
            chk("cap_run_done", done_o, 1'b1);
        end

        // Alternating read/write with fixed 3-cycle latency
        g_lat = 3; g_alt = 1; alt_bit = 0;
        run_until_done(8, 60);
        chk("alt_reads", reads_o, 4);
        chk("alt_writes", writes_o, 4);
        chk("alt_err", err_o, 1'b0);
        chk("alt_latency", outstanding_sum_o / 8, 3);
        g_alt = 0;

        // Issue plus two returns in the same cycle with 2 credits left -> 3 credits
        g_lat = 0; g_v = 0;
        p_start = 1; p_num = 10;
        step();
        g_v = 1;
        steps(2);
        p_dv = 1; p_wd = 1;
        step();
        n_issue = 0;
        steps(5);
        chk("triple_update_issues", n_issue, 3);
        p_reset = 1;
        step();
        rq.delete();
        step();

        // Spurious response while idle, then start with zero requests clears it
        p_dv = 1;
        steps(2);
        chk("spurious_err", err_o, 1'b1);
        n_issue = 0;
        p_start = 1; p_num = 0;
        step();
        step();
        chk("zero_done", done_o, 1'b1);
        chk("zero_err_clr", err_o, 1'b0);
        chk("zero_cycles", cycles_o, 0);
        chk("zero_issues", n_issue, 0);

        // Reset with 3 in flight; late responses are spurious
        g_lat = 0; g_v = 1;
        p_start = 1; p_num = 10;
        step();
        steps(3);
        g_v = 0;
        step();
        p_reset = 1;
        step();
        chk("midrst_busy", busy_o, 1'b0);
        chk("midrst_done", done_o, 1'b0);
        release_held();
        steps(5);
        chk("midrst_late_err", err_o, 1'b1);
        g_v = 1; g_lat = 2;
        run_until_done(4, 40);
        chk("midrst_rerun_err", err_o, 1'b0);

        // Randomized runs
        g_rand = 1;
        for (int r = 0; r < 12; r++) begin
            run_until_done(int'($urandom_range(1, 20)), 400);
            steps(int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bsg_test_master_stats.md
Name: bsg_test_master_stats

Overview:
- Next-generation DRAM bandwidth test master.
- Issues a programmable number of read/write channel requests from an upstream address stream into a DRAM channel interface.
- Caps in-flight requests with a credit counter and returns credits on read data and write acknowledgements.
- Runs a start/drain/done sequence and accumulates bandwidth and occupancy statistics; average latency = outstanding_sum / total responses (Little's law).

Parameters:
- channel_addr_width_p, "inv", width of channel address.
- max_outstanding_p, "inv", maximum in-flight requests (credit pool size), >=1.
- count_width_p, 32, width of request-count input and all statistics counters.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- start_i  in  1  pulse; starts a run when idle or done
- num_req_i  in  count_width_p  requests to issue this run; sampled on start
- v_i  in  1  upstream request valid
- ch_addr_i  in  channel_addr_width_p  upstream address
- write_not_read_i  in  1  upstream request type
- yumi_o  out  1  upstream request consumed
- dram_v_o  out  1  request valid to DRAM
- dram_ch_addr_o  out  channel_addr_width_p  passthrough of ch_addr_i
- dram_write_not_read_o  out  1  passthrough of write_not_read_i
- dram_yumi_i  in  1  DRAM accepts request
- dram_data_v_i  in  1  read data returned (one credit)
- dram_write_done_i  in  1  write acknowledged (one credit)
- busy_o  out  1  state is RUN or DRAIN
- done_o  out  1  state is DONE
- err_o  out  1  sticky: response arrived with credits already full
- cycles_o  out  count_width_p  cycles spent in RUN+DRAIN
- reads_o, writes_o  out  count_width_p  requests issued, by type
- outstanding_sum_o  out  count_width_p  per-cycle sum of in-flight count
- max_outstanding_o  out  `BSG_WIDTH(max_outstanding_p)  peak in-flight count

Behaviour:
- Reset:
  - state IDLE; credits = max_outstanding_p; all statistics 0; err_o 0.
  - yumi_o, dram_v_o, busy_o, done_o all 0.
- FSM states:
  - IDLE: on start_i go to RUN; latch num_req_i; clear statistics and err_o. If num_req_i==0, go directly to DONE.
  - RUN: issue requests. After the issue that makes issued == target, go to DRAIN.
  - DRAIN: stay until credits == max_outstanding_p, then go to DONE. DRAIN lasts at least one cycle.
  - DONE: hold statistics. start_i restarts the run exactly as from IDLE.
  - start_i is ignored in RUN and DRAIN.
- Issue rule (combinational, no dependence on yumi):
  - dram_v_o = (state==RUN) & v_i & (credits != 0).
  - yumi_o = dram_v_o & dram_yumi_i.
  - An issue occurs when yumi_o=1.
  - dram_ch_addr_o and dram_write_not_read_o are pure passthroughs; their value is meaningful only when dram_v_o=1.
- Credits, per cycle:
  - Next credits = credits − issue + dram_data_v_i + dram_write_done_i. A cycle can add up to 2 and subtract 1.
  - Credits are clamped at max_outstanding_p. Any response that would exceed the max sets err_o; that excess is dropped.
  - Credits are returned in every state, including IDLE and DONE. Late responses after reset still set err_o.
- In-flight count = max_outstanding_p − credits, registered value.
- Statistics: update only while busy, and saturate at all-ones.
  - cycles_o increments every busy cycle.
  - reads_o / writes_o increment on each issue, by type.
  - outstanding_sum_o adds the current in-flight count each busy cycle.
  - max_outstanding_o is the running maximum of the post-update in-flight count.
- Latency: zero-cycle request path. The credit consumed by an issue is unavailable from the next cycle. A credit returned in cycle t can be used in cycle t+1.
- Reset mid-run: everything returns to reset values immediately. Responses still outstanding at that point are treated as spurious (see above).

Decomposition:
- Package bsg_test_master_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE}.
  - Packed struct for the statistics bundle.
  - Helper constant for the credit width, `BSG_WIDTH(max_outstanding_p)`.
- One sub-module, bsg_test_master_credit:
  - Up-by-0..2 / down-by-0..1 clamped counter with overflow flag.
  - Outputs credits and the in-flight count.
- Statistics counters stay inline.

Test Plan:
- max_outstanding_p=4, num_req=10, v_i=1, dram_yumi_i=1, no responses → exactly 4 issues, then dram_v_o=0. Return 1 read → 1 issue the next cycle. max_outstanding_o=4.
- num_req=8, alternating read/write, fixed 3-cycle response latency → done_o after drain. reads_o=4, writes_o=4, err_o=0. outstanding_sum_o/8 = 3.
- Same cycle: issue plus dram_data_v_i plus dram_write_done_i with credits=2 → credits=3 next cycle.
- Response with credits full (in IDLE) → err_o=1, credits stay at 4. A later start clears err_o.
- start with num_req=0 → DONE the next cycle; no dram_v_o; all statistics 0.
- Reset asserted in RUN with 3 in flight → next cycle IDLE with credits=4. The subsequent 3 responses set err_o; no credit overflow.
